// File: rtl/calc_sequencer.sv
// Calculator control FSM: builds decimal operands from key strobes, sequences
// the external ALU through a start/done handshake and drives the display.
module calc_sequencer #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned MAX_DIGITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_pressed,
  input  logic             is_num,
  input  logic             is_op,
  input  logic             is_eq,
  input  logic             clear,
  input  logic [3:0]       num_val,
  input  logic [1:0]       op_val,
  output logic             alu_start,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_err,
  output logic [WIDTH-1:0] disp_val,
  output logic             disp_err,
  output logic             busy
);

  localparam int unsigned CW = $clog2(MAX_DIGITS + 1);

  typedef enum logic [2:0] {
    ENTER_A  = 3'd0,
    ENTER_B  = 3'd1,
    WAIT_ALU = 3'd2,
    RESULT   = 3'd3,
    ERROR    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d, pend_op_q, pend_op_d;
  logic             pend_q, pend_d, clrp_q, clrp_d;

  logic             start_d, disp_err_d, busy_d;
  logic [WIDTH-1:0] alu_a_d, alu_b_d, disp_val_d;
  logic [1:0]       alu_op_d;

  logic             key_clr, key_eq, key_op, key_num, digit_room;
  logic             full_clr, issue;
  logic [WIDTH-1:0] a_app, b_app;

  // Key decode with priority clear > eq > op > num; out-of-range digits are no key
  assign key_clr    = btn_pressed & clear;
  assign key_eq     = btn_pressed & ~clear & is_eq;
  assign key_op     = btn_pressed & ~clear & ~is_eq & is_op;
  assign key_num    = btn_pressed & ~clear & ~is_eq & ~is_op & is_num & (num_val <= 4'd9);
  assign digit_room = (cnt_q < CW'(MAX_DIGITS));
  assign a_app      = a_q * WIDTH'(10) + WIDTH'(num_val);
  assign b_app      = b_q * WIDTH'(10) + WIDTH'(num_val);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ENTER_A;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
      pend_op_q <= '0;
      pend_q    <= 1'b0;
      clrp_q    <= 1'b0;
      alu_start <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      disp_val  <= '0;
      disp_err  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      pend_op_q <= pend_op_d;
      pend_q    <= pend_d;
      clrp_q    <= clrp_d;
      alu_start <= start_d;
      alu_a     <= alu_a_d;
      alu_b     <= alu_b_d;
      alu_op    <= alu_op_d;
      disp_val  <= disp_val_d;
      disp_err  <= disp_err_d;
      busy      <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    pend_op_d = pend_op_q;
    pend_d    = pend_q;
    clrp_d    = clrp_q;
    start_d   = 1'b0;
    alu_a_d   = alu_a;
    alu_b_d   = alu_b;
    alu_op_d  = alu_op;
    full_clr  = 1'b0;
    issue     = 1'b0;

    unique case (state_q)
      ENTER_A: begin
        if (key_clr) begin
          full_clr = 1'b1;
        end else if (key_op) begin
          op_d    = op_val;
          b_d     = '0;
          cnt_d   = '0;
          state_d = ENTER_B;
        end else if (key_num && digit_room) begin
          a_d   = a_app;
          cnt_d = cnt_q + CW'(1);
        end
      end
      ENTER_B: begin
        if (key_clr) begin
          full_clr = 1'b1;
        end else if (key_eq && cnt_q != '0) begin
          issue  = 1'b1;
          pend_d = 1'b0;
        end else if (key_op) begin
          if (cnt_q == '0) begin
            op_d = op_val;
          end else begin
            issue     = 1'b1;
            pend_d    = 1'b1;
            pend_op_d = op_val;
          end
        end else if (key_num && digit_room) begin
          b_d   = b_app;
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_ALU: begin
        // A clear arriving with alu_done still counts as pending for that done
        if (key_clr) clrp_d = 1'b1;
        if (alu_done) begin
          if (clrp_q || key_clr) begin
            full_clr = 1'b1;
          end else if (alu_err) begin
            state_d = ERROR;
          end else begin
            a_d = alu_result;
            if (pend_q) begin
              op_d    = pend_op_q;
              pend_d  = 1'b0;
              b_d     = '0;
              cnt_d   = '0;
              state_d = ENTER_B;
            end else begin
              state_d = RESULT;
            end
          end
        end
      end
      RESULT: begin
        if (key_clr) begin
          full_clr = 1'b1;
        end else if (key_op) begin
          op_d    = op_val;
          b_d     = '0;
          cnt_d   = '0;
          state_d = ENTER_B;
        end else if (key_num) begin
          a_d     = WIDTH'(num_val);
          cnt_d   = CW'(1);
          state_d = ENTER_A;
        end
      end
      ERROR: begin
        if (key_clr) full_clr = 1'b1;
      end
      default: full_clr = 1'b1;
    endcase

    if (issue) begin
      start_d  = 1'b1;
      alu_a_d  = a_q;
      alu_b_d  = b_q;
      alu_op_d = op_q;
      state_d  = WAIT_ALU;
    end

    if (full_clr) begin
      a_d       = '0;
      b_d       = '0;
      cnt_d     = '0;
      op_d      = '0;
      pend_op_d = '0;
      pend_d    = 1'b0;
      clrp_d    = 1'b0;
      state_d   = ENTER_A;
    end
  end

  // Display/status outputs follow the next state so they land one cycle after the key
  always_comb begin
    busy_d     = (state_d == WAIT_ALU);
    disp_err_d = (state_d == ERROR);
    unique case (state_d)
      ENTER_B: disp_val_d = (cnt_d != '0) ? b_d : a_d;
      ERROR:   disp_val_d = '0;
      default: disp_val_d = a_d;
    endcase
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: a calculator-level reference model is
// stepped alongside the DUT and compared every cycle, plus literal pin checks.
module tb_calc_sequencer;

  localparam int unsigned WIDTH = 16;
  localparam int MAXD = 4;
  localparam int S_A = 0, S_B = 1, S_W = 2, S_R = 3, S_E = 4;

  logic clk, reset;
  logic btn_pressed, is_num, is_op, is_eq, clear;
  logic [3:0] num_val;
  logic [1:0] op_val;
  logic alu_start, alu_done, alu_err;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result, disp_val;
  logic [1:0] alu_op;
  logic disp_err, busy;

  int n_checks = 0;
  int n_fail = 0;

  // Calculator model state
  int m_st, m_a, m_b, m_n, m_op, m_pend, m_clrp;
  int m_start, m_aa, m_ab, m_aop;

  calc_sequencer #(.WIDTH(WIDTH), .MAX_DIGITS(MAXD)) dut (
    .clk(clk), .reset(reset), .btn_pressed(btn_pressed), .is_num(is_num),
    .is_op(is_op), .is_eq(is_eq), .clear(clear), .num_val(num_val),
    .op_val(op_val), .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_done(alu_done), .alu_result(alu_result),
    .alu_err(alu_err), .disp_val(disp_val), .disp_err(disp_err), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_full_clear();
    m_st = S_A; m_a = 0; m_b = 0; m_n = 0; m_op = 0; m_pend = -1; m_clrp = 0;
  endtask

  task automatic m_reset();
    m_full_clear();
    m_start = 0; m_aa = 0; m_ab = 0; m_aop = 0;
  endtask

  task automatic m_issue(input int pend);
    m_aa = m_a; m_ab = m_b; m_aop = m_op; m_pend = pend;
    m_start = 1; m_st = S_W;
  endtask

  function automatic int m_disp();
    if (m_st == S_E) return 0;
    if (m_st == S_B && m_n > 0) return m_b;
    return m_a;
  endfunction

  // One clock of calculator behaviour for the key/ALU inputs seen at this edge
  task automatic m_step(input bit b, input bit n, input bit o, input bit e, input bit c,
                        input int nv, input int ov, input bit d, input int r, input bit er);
    bit kc, ke, ko, kn;
    kc = b && c;
    ke = b && !c && e;
    ko = b && !c && !e && o;
    kn = b && !c && !e && !o && n && (nv <= 9);
    m_start = 0;
    case (m_st)
      S_A: if (kc) m_full_clear();
           else if (ko) begin m_op = ov; m_b = 0; m_n = 0; m_st = S_B; end
           else if (kn && m_n < MAXD) begin m_a = m_a * 10 + nv; m_n++; end
      S_B: if (kc) m_full_clear();
           else if (ke && m_n > 0) m_issue(-1);
           else if (ko) begin
             if (m_n == 0) m_op = ov; else m_issue(ov);
           end
           else if (kn && m_n < MAXD) begin m_b = m_b * 10 + nv; m_n++; end
      S_W: begin
        if (kc) m_clrp = 1;
        if (d) begin
          if (m_clrp != 0) m_full_clear();
          else if (er) m_st = S_E;
          else begin
            m_a = r;
            if (m_pend >= 0) begin
              m_op = m_pend; m_pend = -1; m_b = 0; m_n = 0; m_st = S_B;
            end else m_st = S_R;
          end
        end
      end
      S_R: if (kc) m_full_clear();
           else if (ko) begin m_op = ov; m_b = 0; m_n = 0; m_st = S_B; end
           else if (kn) begin m_a = nv; m_n = 1; m_st = S_A; end
      default: if (kc) m_full_clear();
    endcase
  endtask

  // Every-cycle comparison of DUT against the model
  always @(negedge clk) begin
    chk("disp_val", disp_val, m_disp());
    chk("disp_err", disp_err, (m_st == S_E) ? 1 : 0);
    chk("busy", busy, (m_st == S_W) ? 1 : 0);
    chk("alu_start", alu_start, m_start);
    if (m_st == S_W) begin
      chk("alu_a", alu_a, m_aa);
      chk("alu_b", alu_b, m_ab);
      chk("alu_op", alu_op, m_aop);
    end
  end

  task automatic step(input bit b, input bit n, input bit o, input bit e, input bit c,
                      input int nv, input int ov, input bit d, input int r, input bit er);
    btn_pressed = b; is_num = n; is_op = o; is_eq = e; clear = c;
    num_val = 4'(nv); op_val = 2'(ov);
    alu_done = d; alu_result = WIDTH'(r); alu_err = er;
    @(posedge clk);
    m_step(b, n, o, e, c, nv, ov, d, r, er);
    @(negedge clk);
  endtask

  task automatic num(input int v);  step(1, 1, 0, 0, 0, v, 0, 0, 0, 0); endtask
  task automatic opk(input int v);  step(1, 0, 1, 0, 0, 0, v, 0, 0, 0); endtask
  task automatic eqk();             step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0); endtask
  task automatic clr();             step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0); endtask
  task automatic idle(input int k); repeat (k) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic done(input int r, input bit er); step(0, 0, 0, 0, 0, 0, 0, 1, r, er); endtask

  initial begin
    reset = 1'b0;
    btn_pressed = 0; is_num = 0; is_op = 0; is_eq = 0; clear = 0;
    num_val = '0; op_val = '0; alu_done = 0; alu_result = '0; alu_err = 0;
    m_reset();
    repeat (2) @(negedge clk);
    chk("reset_disp", disp_val, 0);
    chk("reset_busy", busy, 0);
    reset = 1'b1;

    // 12 + 3 = 15, then continue from the result: 15 + 1 = 16
    num(1); num(2);
    chk("t1_disp12", disp_val, 12);
    opk(0);
    chk("t1_disp_a", disp_val, 12);
    num(3);
    chk("t1_disp3", disp_val, 3);
    eqk();
    chk("t1_start", alu_start, 1);
    chk("t1_a", alu_a, 12);
    chk("t1_b", alu_b, 3);
    chk("t1_op", alu_op, 0);
    idle(2);
    chk("t1_start_once", alu_start, 0);
    done(15, 0);
    chk("t1_result", disp_val, 15);
    chk("t1_not_busy", busy, 0);
    eqk();
    chk("t1_eq_ignored", busy, 0);
    opk(0); num(1); eqk();
    chk("t1_chain_a", alu_a, 15);
    done(16, 0);
    chk("t1_chain_res", disp_val, 16);

    // Digit limit and out-of-range digit value
    clr();
    num(12);
    chk("t2_bad_digit", disp_val, 0);
    repeat (5) num(9);
    chk("t2_9999", disp_val, 9999);
    step(1, 1, 0, 0, 0, 12, 0, 0, 0, 0);
    chk("t2_still_9999", disp_val, 9999);

    // 8 + (replaced by x) 2 - 1 = 15, pending operator chain
    clr(); num(8); opk(0); opk(2); num(2); opk(1);
    chk("t3_a1", alu_a, 8);
    chk("t3_op1", alu_op, 2);
    idle(1);
    done(16, 0);
    chk("t3_disp16", disp_val, 16);
    chk("t3_busy_low", busy, 0);
    num(1); eqk();
    chk("t3_a2", alu_a, 16);
    chk("t3_b2", alu_b, 1);
    chk("t3_op2", alu_op, 1);
    idle(1);
    done(15, 0);
    chk("t3_result", disp_val, 15);
    num(4);
    chk("t3_new_a", disp_val, 4);

    // 5 / 0 -> ALU error
    clr(); num(5); opk(3); num(0); eqk(); idle(1);
    done(0, 1);
    chk("t4_err", disp_err, 1);
    chk("t4_disp0", disp_val, 0);
    num(3);
    chk("t4_digit_ignored", disp_val, 0);
    clr();
    chk("t4_cleared", disp_err, 0);

    // Eq with empty B ignored; clear during WAIT_ALU discards result
    num(7); opk(0); eqk();
    chk("t5_eq_empty_b", busy, 0);
    num(3); eqk(); clr(); idle(3);
    chk("t5_still_busy", busy, 1);
    done(7, 0);
    chk("t5_discard", disp_val, 0);
    chk("t5_idle", busy, 0);

    // Clear in the same cycle as done; stray done; clear priority over digit
    num(2); opk(0); num(2); eqk();
    step(1, 0, 0, 0, 1, 0, 0, 1, 4, 0);
    chk("t6_same_cycle_clr", disp_val, 0);
    done(55, 0);
    chk("t6_stray_done", disp_val, 0);
    num(6);
    step(1, 1, 0, 0, 1, 5, 0, 0, 0, 0);
    chk("t6_clr_priority", disp_val, 0);

    // Asynchronous reset while busy, then a late done
    num(4); opk(0); num(5); eqk(); idle(1);
    chk("t7_busy", busy, 1);
    #2 reset = 1'b0;
    m_reset();
    #1;
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_disp", disp_val, 5 - 5);
    chk("t7_rst_a", alu_a, 0);
    chk("t7_rst_b", alu_b, 0);
    @(negedge clk);
    reset = 1'b1;
    done(9, 0);
    chk("t7_late_done", disp_val, 0);
    chk("t7_late_busy", busy, 0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
